ifetch_queue: RTL and testbench
===============================

// Module: ifetch_queue
// PURPOSE
// Decoupled instruction-fetch front end: owns the PC, issues ibus requests ahead of decode and
// buffers {pc, instr, fault} in a DEPTH-entry FIFO, so a consumer stall no longer blocks the PC.
// Sits between the ibus and the decode stage register. Redirects from execute or trap flush
// the queue. An in-flight ibus request is never abandoned; its response is drained and dropped.
// PARAMETERS
// DEPTH     4               FIFO entries; power of two, >= 2
// XLEN      64              PC / address width
// RESET_PC  64'h8000_0000   PC loaded at reset
// PORTS
// clk             in   1     clock
// reset           in   1     synchronous reset, active-low (0 = reset)
// ireq_valid      out  1     ibus request valid
// ireq_addr       out  XLEN  ibus request address
// iresp_data_ok   in   1     ibus response strobe, one cycle per accepted request
// iresp_data      in   32    instruction word, valid with iresp_data_ok
// redirect_valid  in   1     flush queue, restart fetch at redirect_pc
// redirect_pc     in   XLEN  new fetch PC
// out_valid       out  1     head entry valid
// out_ready       in   1     consumer accepts head this cycle
// out_pc          out  XLEN  head PC
// out_instr       out  32    head instruction; 0 when out_fault
// out_fault       out  1     head PC misaligned (pc[1:0] != 0); no bus access made
// BEHAVIOUR
// - Reset (reset==0 at posedge): pc=RESET_PC, FIFO empty, state IDLE; ireq_valid=0,
//   ireq_addr=RESET_PC, out_valid=0, out_pc=0, out_instr=0, out_fault=0.
// - Bus rule: once ireq_valid=1, ireq_valid and ireq_addr stay stable until iresp_data_ok.
//   At most one request outstanding.
// - Credit: issue only if count + outstanding < DEPTH; a pop in the same cycle does not free
//   credit until the next cycle.
// - States:
//   IDLE : ireq_valid=0. If credit and pc[1:0]==0 -> REQ (ireq_valid=1 next cycle, addr=pc).
//          If credit and pc[1:0]!=0 -> push {pc,0,fault=1} with no bus access, stay IDLE,
//          stop fetching until redirect.
//   REQ  : ireq_valid=1. On data_ok: push {pc, iresp_data, 0}, pc<=pc+4 (mod 2^XLEN);
//          -> REQ if credit remains and the new pc is aligned, else IDLE.
//   DRAIN: ireq_valid=1 at the old address. On data_ok: discard data, pc<=pending target,
//          -> IDLE.
// - Redirect (highest priority): FIFO cleared, count=0 the same edge. Pop ignored that cycle.
//   - In IDLE -> pc<=redirect_pc, IDLE.
//   - In REQ without data_ok -> store target, DRAIN.
//   - In REQ with data_ok the same cycle -> response dropped, pc<=redirect_pc, IDLE.
//   - In DRAIN -> target overwritten by newest redirect_pc; with data_ok the same cycle,
//     go to IDLE and use the newest target.
// - FIFO: circular, $clog2(DEPTH)-bit pointers plus count. out_* are driven from head.
//   Pop when out_valid & out_ready. Push and pop in the same cycle are both legal.
//   out_valid = (count != 0).
// - Latency: data_ok at cycle t -> out_valid at t+1. Aligned sequential stream with
//   out_ready=1 sustains 1 instr per bus response.
// - Reset mid-request: state, FIFO and pc reinitialise. A stale data_ok arriving after reset
//   is ignored, because IDLE never accepts data.
// CONFIGURATION
// IFETCH_BYPASS_EN defined: if FIFO empty, state REQ, data_ok=1, out_ready=1 and no redirect,
//   the response goes to out_* combinationally in the same cycle (out_valid=1) and is not
//   pushed. Zero-cycle fetch-to-decode latency.
// Undefined: every response goes through the FIFO; minimum latency is 1 cycle.
// TESTING
// 1 Reset release, bus answers data_ok 1 cycle after each request, out_ready=1
//   -> out_pc 0x8000_0000, 0x8000_0004, 0x8000_0008 in order, out_fault=0.
// 2 out_ready=0, DEPTH=4 -> exactly 4 requests complete, then ireq_valid=0.
//   Raise out_ready -> fetch resumes at 0x8000_0010.
// 3 Redirect to 0x8000_0100 while a request to 0x8000_0008 is pending, data_ok 3 cycles later
//   -> ireq_addr held at 0x8000_0008 until data_ok; that instr never appears on out_*;
//   next out_pc = 0x8000_0100.
// 4 Redirect and data_ok in the same cycle -> response dropped; FIFO empty next cycle;
//   next request addr = redirect_pc.
// 5 Redirect to 0x8000_0102 -> ireq_valid stays 0; out_valid=1, out_pc=0x8000_0102,
//   out_fault=1, out_instr=0; no further entries until the next redirect.
// 6 Reset low for 1 cycle with a request outstanding, then a late data_ok
//   -> no entry pushed; first request after reset is to 0x8000_0000.
// 7 IFETCH_BYPASS_EN, FIFO empty, data_ok with instr 0x00000013 -> out_valid=1 and
//   out_instr=0x00000013 in the same cycle; count stays 0.

Source files
------------

// File: rtl/ifetch_queue.sv
// ifetch_queue: decoupled instruction-fetch front end.
// Owns the fetch PC and issues single-outstanding ibus requests. Fetched
// {pc, instr, fault} entries are buffered in a DEPTH-entry circular FIFO
// ahead of decode, so a decode stall does not block the PC. A redirect flushes
// the queue. If a request is in flight when the redirect arrives, the request
// is allowed to complete and its response is discarded.
//
// Ports
//   clk, reset                 clock, synchronous active-low reset
//   ireq_valid, ireq_addr      ibus request (held stable until iresp_data_ok)
//   iresp_data_ok, iresp_data  ibus response strobe and instruction word
//   redirect_valid/_pc         flush and restart fetch at redirect_pc
//   out_valid/_ready           head-of-queue handshake toward decode
//   out_pc/_instr/_fault       head entry; fault marks a misaligned PC (instr=0)
//
// Build option
//   IFETCH_BYPASS_EN  when defined, a response that arrives while the FIFO is
//                     empty and decode is ready is forwarded combinationally
//                     to out_* in the same cycle and is not written into the FIFO.

module ifetch_queue #(
   parameter int unsigned     DEPTH    = 4,
   parameter int unsigned     XLEN     = 64,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
   input  logic            clk,
   input  logic            reset,
   output logic            ireq_valid,
   output logic [XLEN-1:0] ireq_addr,
   input  logic            iresp_data_ok,
   input  logic [31:0]     iresp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [31:0]     out_instr,
   output logic            out_fault
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned SUM_W = CNT_W + 1;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     instr;
      logic            fault;
   } entry_t;

   typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

   state_t           state, state_nxt;
   logic [XLEN-1:0]  pc, pc_nxt;
   logic [XLEN-1:0]  target, target_nxt;
   logic             stopped, stopped_nxt;

   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] head, tail;
   logic [CNT_W-1:0] count;

   logic             push;
   entry_t           push_entry;
   logic             pop;
   logic             bypass;
   logic             credit;
   logic             room_after_rsp;

   // Forward a response straight to decode when nothing is queued ahead of it.
`ifdef IFETCH_BYPASS_EN
   assign bypass = reset && (state == REQ) && iresp_data_ok && out_ready &&
                   !redirect_valid && (count == '0);
`else
   assign bypass = 1'b0;
`endif

   // Credit uses the registered count, so a same-cycle pop frees nothing yet.
   assign credit = (count < CNT_W'(DEPTH));

   // After a response lands (pushed or bypassed), a new request needs one more free slot.
   assign room_after_rsp = ({1'b0, count} + SUM_W'(!bypass)) < SUM_W'(DEPTH);

   assign pop = reset && !redirect_valid && out_ready && (count != '0);

   // State register
   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state and datapath control
   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc;
      target_nxt  = target;
      stopped_nxt = stopped;
      push        = 1'b0;
      push_entry  = '0;
      case (state)
         IDLE: begin
            if (redirect_valid) begin
               pc_nxt      = redirect_pc;
               stopped_nxt = 1'b0;
            end else if (credit && !stopped) begin
               if (pc[1:0] == 2'b00) begin
                  state_nxt = REQ;
               end else begin
                  // Misaligned PC: report it once, then wait for a redirect.
                  push        = 1'b1;
                  push_entry  = '{pc: pc, instr: 32'h0, fault: 1'b1};
                  stopped_nxt = 1'b1;
               end
            end
         end
         REQ: begin
            if (redirect_valid) begin
               stopped_nxt = 1'b0;
               if (iresp_data_ok) begin
                  pc_nxt    = redirect_pc;
                  state_nxt = IDLE;
               end else begin
                  target_nxt = redirect_pc;
                  state_nxt  = DRAIN;
               end
            end else if (iresp_data_ok) begin
               push       = !bypass;
               push_entry = '{pc: pc, instr: iresp_data, fault: 1'b0};
               pc_nxt     = pc + XLEN'(4);
               if (room_after_rsp && (pc_nxt[1:0] == 2'b00)) state_nxt = REQ;
               else                                          state_nxt = IDLE;
            end
         end
         DRAIN: begin
            if (redirect_valid) begin
               target_nxt  = redirect_pc;
               stopped_nxt = 1'b0;
            end
            if (iresp_data_ok) begin
               pc_nxt    = redirect_valid ? redirect_pc : target;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs: the request is held at pc (which is frozen in REQ/DRAIN); out_* comes from the head entry
   always_comb begin
      ireq_valid = (state != IDLE);
      ireq_addr  = pc;
      out_valid  = 1'b0;
      out_pc     = '0;
      out_instr  = '0;
      out_fault  = 1'b0;
      if (bypass) begin
         out_valid = 1'b1;
         out_pc    = pc;
         out_instr = iresp_data;
      end else if (count != '0) begin
         out_valid = 1'b1;
         out_pc    = mem[head].pc;
         out_instr = mem[head].instr;
         out_fault = mem[head].fault;
      end
   end

   // Fetch PC, pending redirect target, misalignment stop flag
   always_ff @(posedge clk) begin
      if (!reset) begin
         pc      <= RESET_PC;
         target  <= RESET_PC;
         stopped <= 1'b0;
      end else begin
         pc      <= pc_nxt;
         target  <= target_nxt;
         stopped <= stopped_nxt;
      end
   end

   // FIFO pointers and occupancy; a redirect empties the queue the same edge
   always_ff @(posedge clk) begin
      if (!reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (redirect_valid) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + PTR_W'(1);
         if (pop)  head <= head + PTR_W'(1);
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // FIFO storage
   always_ff @(posedge clk) begin
      if (reset && push) mem[tail] <= push_entry;
   end

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: scoreboard bench for ifetch_queue.
// Stimulus pushes expected head entries into exp_q; a negedge monitor pops
// and compares whenever decode accepts an entry. The ibus is either an
// automatic responder (fixed wait states) or driven directly by the stimulus.

module tb_ifetch_queue;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
      logic        fault;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        ireq_valid;
   logic [63:0] ireq_addr;
   logic        iresp_data_ok;
   logic [31:0] iresp_data;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_pc;
   logic [31:0] out_instr;
   logic        out_fault;

   logic        bus_auto;
   logic        auto_ok;
   logic        man_ok;
   logic [31:0] auto_data;
   logic [31:0] man_data;
   int          bus_lat;
   int          bus_cnt;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          ok_count = 0;

   assign iresp_data_ok = bus_auto ? auto_ok   : man_ok;
   assign iresp_data    = bus_auto ? auto_data : man_data;

   ifetch_queue dut (
      .clk            (clk),
      .reset          (reset),
      .ireq_valid     (ireq_valid),
      .ireq_addr      (ireq_addr),
      .iresp_data_ok  (iresp_data_ok),
      .iresp_data     (iresp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_instr      (out_instr),
      .out_fault      (out_fault)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [63:0] pc, input logic [31:0] instr, input logic fault);
      exp_t e;
      e.pc    = pc;
      e.instr = instr;
      e.fault = fault;
      exp_q.push_back(e);
   endtask

   task automatic wait_req();
      int n = 0;
      while (!ireq_valid && n < 64) begin
         tick();
         n++;
      end
      chk("req_issued", 64'(ireq_valid), 64'd1);
   endtask

   // Waits for a request, checks its address, answers it in that cycle.
   task automatic serve(input logic [63:0] addr, input logic [31:0] data);
      wait_req();
      chk("req_addr", ireq_addr, addr);
      man_data = data;
      man_ok   = 1'b1;
      tick();
      man_ok   = 1'b0;
   endtask

   task automatic reset_dut();
      out_ready      = 1'b0;
      redirect_valid = 1'b0;
      bus_auto       = 1'b0;
      man_ok         = 1'b0;
      reset          = 1'b0;
      tick();
      exp_q.delete();
      reset          = 1'b1;
   endtask

   // Automatic ibus: answers each request after bus_lat wait cycles.
   initial begin
      auto_ok   = 1'b0;
      auto_data = '0;
      bus_cnt   = 0;
      forever begin
         @(posedge clk);
         #1;
         if (auto_ok) begin
            auto_ok = 1'b0;
            bus_cnt = 0;
         end
         if (bus_auto && reset && ireq_valid) begin
            if (bus_cnt >= bus_lat) begin
               auto_ok   = 1'b1;
               auto_data = ireq_addr[31:0] + 32'h13;
            end else begin
               bus_cnt++;
            end
         end else begin
            bus_cnt = 0;
         end
      end
   end

   // Completed bus transactions
   initial forever begin
      @(negedge clk);
      if (reset && iresp_data_ok && ireq_valid) ok_count++;
   end

   // Scoreboard monitor
   initial forever begin
      @(negedge clk);
      if (reset && !redirect_valid && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_out: got pc 0x%0h, expected no entry", out_pc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_pc",    out_pc,            e.pc);
            chk("sb_instr", 64'(out_instr),    64'(e.instr));
            chk("sb_fault", 64'(out_fault),    64'(e.fault));
         end
      end
   end

   initial begin
      int n;
      int base;
      reset          = 1'b0;
      out_ready      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      bus_auto       = 1'b0;
      bus_lat        = 1;
      man_ok         = 1'b0;
      man_data       = '0;

      // Reset state
      tick();
      tick();
      chk("rst_ireq_valid", 64'(ireq_valid), 64'd0);
      chk("rst_ireq_addr",  ireq_addr,       64'h8000_0000);
      chk("rst_out_valid",  64'(out_valid),  64'd0);
      chk("rst_out_pc",     out_pc,          64'd0);
      chk("rst_out_instr",  64'(out_instr),  64'd0);
      chk("rst_out_fault",  64'(out_fault),  64'd0);
      reset = 1'b1;

      // 1: sequential stream from reset, one wait cycle per request
      reset_dut();
      for (int i = 0; i < 16; i++)
         push_exp(64'h8000_0000 + 64'(4 * i), 32'h8000_0013 + 32'(4 * i), 1'b0);
      out_ready = 1'b1;
      bus_lat   = 1;
      bus_auto  = 1'b1;
      n = 0;
      while (exp_q.size() > 13 && n < 100) begin
         tick();
         n++;
      end
      chk("t1_first_three", 64'(exp_q.size() <= 13), 64'd1);

      // 2: decode stalled -> exactly DEPTH requests, then resume at +0x10
      reset_dut();
      bus_lat  = 1;
      bus_auto = 1'b1;
      base     = ok_count;
      repeat (30) tick();
      chk("t2_req_count",  64'(ok_count - base), 64'd4);
      chk("t2_ireq_idle",  64'(ireq_valid),      64'd0);
      chk("t2_out_valid",  64'(out_valid),       64'd1);
      chk("t2_head_pc",    out_pc,               64'h8000_0000);
      for (int i = 0; i < 8; i++)
         push_exp(64'h8000_0000 + 64'(4 * i), 32'h8000_0013 + 32'(4 * i), 1'b0);
      out_ready = 1'b1;
      wait_req();
      chk("t2_resume_addr", ireq_addr, 64'h8000_0010);
      n = 0;
      while (exp_q.size() > 2 && n < 100) begin
         tick();
         n++;
      end
      chk("t2_stream", 64'(exp_q.size() <= 2), 64'd1);

      // 3: redirect while a request is pending; response dropped three cycles later
      reset_dut();
      out_ready = 1'b1;
      push_exp(64'h8000_0000, 32'h8000_0013, 1'b0);
      push_exp(64'h8000_0004, 32'h8000_0017, 1'b0);
      serve(64'h8000_0000, 32'h8000_0013);
      serve(64'h8000_0004, 32'h8000_0017);
      wait_req();
      chk("t3_pending_addr", ireq_addr, 64'h8000_0008);
      tick();
      tick();
      chk("t3_pre_redirect_drained", 64'(exp_q.size()), 64'd0);
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_0100;
      exp_q.delete();
      tick();
      redirect_valid = 1'b0;
      push_exp(64'h8000_0100, 32'h8000_0113, 1'b0);
      for (int k = 0; k < 3; k++) begin
         chk("t3_drain_valid", 64'(ireq_valid), 64'd1);
         chk("t3_drain_addr",  ireq_addr,       64'h8000_0008);
         if (k == 2) begin
            man_data = 32'hDEAD_BEEF;
            man_ok   = 1'b1;
         end
         tick();
      end
      man_ok = 1'b0;
      #1;
      chk("t3_dropped", 64'(out_valid), 64'd0);
      serve(64'h8000_0100, 32'h8000_0113);
      tick();
      tick();
      chk("t3_sb_empty", 64'(exp_q.size()), 64'd0);

      // 4: redirect and data_ok in the same cycle
      reset_dut();
      out_ready = 1'b1;
      push_exp(64'h8000_0000, 32'h8000_0013, 1'b0);
      serve(64'h8000_0000, 32'h8000_0013);
      wait_req();
      chk("t4_pending_addr", ireq_addr, 64'h8000_0004);
      tick();
      chk("t4_pre_redirect_drained", 64'(exp_q.size()), 64'd0);
      man_data       = 32'hBADC_0DE0;
      man_ok         = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_0200;
      exp_q.delete();
      tick();
      man_ok         = 1'b0;
      redirect_valid = 1'b0;
      #1;
      chk("t4_fifo_empty", 64'(out_valid),  64'd0);
      chk("t4_idle",       64'(ireq_valid), 64'd0);
      push_exp(64'h8000_0200, 32'h8000_0213, 1'b0);
      serve(64'h8000_0200, 32'h8000_0213);
      tick();
      tick();
      chk("t4_sb_empty", 64'(exp_q.size()), 64'd0);

      // 5: misaligned redirect -> fault entry, no bus access, then silence
      reset_dut();
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_0102;
      tick();
      redirect_valid = 1'b0;
      chk("t5_no_req_a", 64'(ireq_valid), 64'd0);
      tick();
      chk("t5_no_req_b",   64'(ireq_valid), 64'd0);
      chk("t5_out_valid",  64'(out_valid),  64'd1);
      chk("t5_out_pc",     out_pc,          64'h8000_0102);
      chk("t5_out_fault",  64'(out_fault),  64'd1);
      chk("t5_out_instr",  64'(out_instr),  64'd0);
      push_exp(64'h8000_0102, 32'h0, 1'b1);
      out_ready = 1'b1;
      tick();
      for (int k = 0; k < 5; k++) begin
         chk("t5_quiet_out", 64'(out_valid),  64'd0);
         chk("t5_quiet_req", 64'(ireq_valid), 64'd0);
         tick();
      end
      chk("t5_sb_empty", 64'(exp_q.size()), 64'd0);

      // 6: reset with a request outstanding, stale data_ok afterwards
      reset_dut();
      out_ready = 1'b1;
      wait_req();
      chk("t6_first_addr", ireq_addr, 64'h8000_0000);
      tick();
      reset = 1'b0;
      tick();
      reset    = 1'b1;
      man_data = 32'h1111_1111;
      man_ok   = 1'b1;
      #1;
      chk("t6_stale_no_out", 64'(out_valid), 64'd0);
      tick();
      man_ok = 1'b0;
      #1;
      chk("t6_no_push",    64'(out_valid),  64'd0);
      chk("t6_req_again",  64'(ireq_valid), 64'd1);
      chk("t6_req_addr",   ireq_addr,       64'h8000_0000);
      push_exp(64'h8000_0000, 32'h8000_0013, 1'b0);
      serve(64'h8000_0000, 32'h8000_0013);
      tick();
      tick();
      chk("t6_sb_empty", 64'(exp_q.size()), 64'd0);

      // 7: fetch-to-decode latency with an empty queue
      reset_dut();
      out_ready = 1'b1;
      push_exp(64'h8000_0000, 32'h0000_0013, 1'b0);
      wait_req();
      man_data = 32'h0000_0013;
      man_ok   = 1'b1;
      #1;
`ifdef IFETCH_BYPASS_EN
      chk("t7_same_cycle_valid", 64'(out_valid), 64'd1);
      chk("t7_same_cycle_instr", 64'(out_instr), 64'h13);
      chk("t7_same_cycle_pc",    out_pc,         64'h8000_0000);
      tick();
      man_ok = 1'b0;
      #1;
      chk("t7_not_pushed", 64'(out_valid), 64'd0);
`else
      chk("t7_not_yet_valid", 64'(out_valid), 64'd0);
      tick();
      man_ok = 1'b0;
      #1;
      chk("t7_next_valid", 64'(out_valid), 64'd1);
      chk("t7_next_instr", 64'(out_instr), 64'h13);
`endif
      tick();
      tick();
      chk("t7_sb_empty", 64'(exp_q.size()), 64'd0);

      reset_dut();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
